// File: rtl/vxe_vpu_mem_arb.sv
// Round-robin arbiter sharing one memory read-request port among NCLI VPU load clients,
// with in-order response routing via an order FIFO. Optional counters: VXE_MARB_STATS_EN.
module vxe_vpu_mem_arb #(
    parameter int NCLI   = 2,
    parameter int ADDR_W = 37,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NCLI-1:0]          i_req_valid,
    input  logic [NCLI*ADDR_W-1:0]   i_req_addr,
    input  logic [NCLI*TAG_W-1:0]    i_req_tag,
    output logic [NCLI-1:0]          o_req_rdy,
    output logic                     o_m_valid,
    output logic [ADDR_W-1:0]        o_m_addr,
    output logic [TAG_W-1:0]         o_m_tag,
    input  logic                     i_m_rdy,
    input  logic                     i_m_rvalid,
    input  logic [DATA_W-1:0]        i_m_rdata,
    input  logic [TAG_W-1:0]         i_m_rtag,
    output logic                     o_m_rrdy,
    output logic [NCLI-1:0]          o_rvalid,
    output logic [DATA_W-1:0]        o_rdata,
    output logic [TAG_W-1:0]         o_rtag,
    input  logic [NCLI-1:0]          i_rrdy
`ifdef VXE_MARB_STATS_EN
    ,
    output logic [31:0]              o_gnt_cnt,
    output logic [31:0]              o_stall_cnt
`endif
);

    // Every channel transfers on a cycle where valid and ready are both high; valid never
    // depends on ready, and a producer holds its payload stable until that transfer happens.
    localparam int CLI_W = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    logic [CLI_W-1:0] rr_ptr;
    logic [CLI_W-1:0] win_id;
    logic [CLI_W-1:0] head;
    logic             win_found;
    logic             reg_free;
    logic             fifo_full;
    logic             fifo_empty;
    logic             grant;
    logic             pop;

    logic [CLI_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign reg_free   = !o_m_valid || i_m_rdy;
    assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign grant      = reg_free && !fifo_full && win_found;
    assign head       = fifo_mem[rd_ptr];
    assign pop        = i_m_rvalid && o_m_rrdy;

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 1; i <= NCLI; i++) begin
            idx = (int'(rr_ptr) + i) % NCLI;
            if (!win_found && i_req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = CLI_W'(idx);
            end
        end
    end

    assign o_req_rdy = grant ? (NCLI'(1) << win_id) : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_m_valid <= 1'b0;
            o_m_addr  <= '0;
            o_m_tag   <= '0;
            rr_ptr    <= CLI_W'(NCLI - 1);
        end else if (grant) begin
            o_m_valid <= 1'b1;
            o_m_addr  <= i_req_addr[int'(win_id)*ADDR_W +: ADDR_W];
            o_m_tag   <= i_req_tag[int'(win_id)*TAG_W +: TAG_W];
            rr_ptr    <= win_id;
        end else if (reg_free) begin
            o_m_valid <= 1'b0;
        end
    end

    // Order FIFO of granted client IDs; the hub returns responses in grant order.
    always_ff @(posedge clk) begin
        if (grant) begin
            fifo_mem[wr_ptr] <= win_id;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({grant, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_rvalid = (i_m_rvalid && !fifo_empty) ? (NCLI'(1) << head) : '0;
    assign o_m_rrdy = !fifo_empty && i_rrdy[head];
    assign o_rdata  = i_m_rdata;
    assign o_rtag   = i_m_rtag;

`ifdef VXE_MARB_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_gnt_cnt   <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (grant && (o_gnt_cnt != 32'hFFFF_FFFF)) begin
                o_gnt_cnt <= o_gnt_cnt + 32'd1;
            end
            if (o_m_valid && !i_m_rdy && (o_stall_cnt != 32'hFFFF_FFFF)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vxe_vpu_mem_arb.sv
// Directed self-checking bench for vxe_vpu_mem_arb (NCLI=2, DEPTH=8); stats checks
// are compiled in when VXE_MARB_STATS_EN is defined.
module tb_vxe_vpu_mem_arb;
    localparam int NCLI   = 2;
    localparam int ADDR_W = 37;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 6;
    localparam int DEPTH  = 8;

    logic                   clk;
    logic                   nrst;
    logic [NCLI-1:0]        i_req_valid;
    logic [NCLI*ADDR_W-1:0] i_req_addr;
    logic [NCLI*TAG_W-1:0]  i_req_tag;
    logic [NCLI-1:0]        o_req_rdy;
    logic                   o_m_valid;
    logic [ADDR_W-1:0]      o_m_addr;
    logic [TAG_W-1:0]       o_m_tag;
    logic                   i_m_rdy;
    logic                   i_m_rvalid;
    logic [DATA_W-1:0]      i_m_rdata;
    logic [TAG_W-1:0]       i_m_rtag;
    logic                   o_m_rrdy;
    logic [NCLI-1:0]        o_rvalid;
    logic [DATA_W-1:0]      o_rdata;
    logic [TAG_W-1:0]       o_rtag;
    logic [NCLI-1:0]        i_rrdy;
`ifdef VXE_MARB_STATS_EN
    logic [31:0]            o_gnt_cnt;
    logic [31:0]            o_stall_cnt;
`endif

    vxe_vpu_mem_arb #(
        .NCLI(NCLI), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .nrst(nrst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_tag(i_req_tag),
        .o_req_rdy(o_req_rdy),
        .o_m_valid(o_m_valid), .o_m_addr(o_m_addr), .o_m_tag(o_m_tag), .i_m_rdy(i_m_rdy),
        .i_m_rvalid(i_m_rvalid), .i_m_rdata(i_m_rdata), .i_m_rtag(i_m_rtag),
        .o_m_rrdy(o_m_rrdy),
        .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_rtag(o_rtag), .i_rrdy(i_rrdy)
`ifdef VXE_MARB_STATS_EN
        , .o_gnt_cnt(o_gnt_cnt), .o_stall_cnt(o_stall_cnt)
`endif
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;
    // Scoreboard: expected one-hot o_rvalid for each outstanding grant, in grant order.
    logic [NCLI-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic [63:0]     d;
        logic [NCLI-1:0] e;
        while (exp_q.size() > 0) begin
            e          = exp_q.pop_front();
            d          = {$urandom, $urandom};
            i_m_rvalid = 1'b1;
            i_m_rdata  = d;
            i_m_rtag   = 6'($urandom_range(0, 63));
            i_rrdy     = '1;
            #1;
            check("drain_rvalid", 64'(o_rvalid), 64'(e));
            check("drain_rrdy", 64'(o_m_rrdy), 64'd1);
            check("drain_rdata", o_rdata, d);
            tick();
        end
        i_m_rvalid = 1'b0;
    endtask

    logic [NCLI-1:0] fair_exp [6];

    initial begin
        fair_exp    = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        nrst        = 1'b0;
        i_req_valid = '0;
        i_req_addr  = '0;
        i_req_tag   = '0;
        i_m_rdy     = 1'b1;
        i_m_rvalid  = 1'b1;
        i_m_rdata   = 64'h1234;
        i_m_rtag    = '0;
        i_rrdy      = '1;

        // Reset state; a stray response must not be accepted with an empty FIFO.
        #2;
        check("rst_m_valid", 64'(o_m_valid), 64'd0);
        check("rst_m_addr", 64'(o_m_addr), 64'd0);
        check("rst_m_tag", 64'(o_m_tag), 64'd0);
        check("rst_req_rdy", 64'(o_req_rdy), 64'd0);
        check("rst_rvalid", 64'(o_rvalid), 64'd0);
        check("rst_m_rrdy", 64'(o_m_rrdy), 64'd0);
`ifdef VXE_MARB_STATS_EN
        check("rst_gnt_cnt", 64'(o_gnt_cnt), 64'd0);
        check("rst_stall_cnt", 64'(o_stall_cnt), 64'd0);
`endif
        i_m_rvalid = 1'b0;
        repeat (2) tick();
        nrst = 1'b1;
        tick();

        // Idle
        for (int i = 0; i < 10; i++) begin
            check("idle_m_valid", 64'(o_m_valid), 64'd0);
            check("idle_req_rdy", 64'(o_req_rdy), 64'd0);
            check("idle_rvalid", 64'(o_rvalid), 64'd0);
            tick();
        end

        // Single request from client 1
        i_req_addr  = {37'h100, 37'h0};
        i_req_tag   = {6'd5, 6'd0};
        i_req_valid = 2'b10;
        #1;
        check("single_req_rdy", 64'(o_req_rdy), 64'h2);
        exp_q.push_back(2'b10);
        tick();
        i_req_valid = '0;
        check("single_m_valid", 64'(o_m_valid), 64'd1);
        check("single_m_addr", 64'(o_m_addr), 64'h100);
        check("single_m_tag", 64'(o_m_tag), 64'd5);
        tick();
        check("single_drop_valid", 64'(o_m_valid), 64'd0);
        check("single_hold_addr", 64'(o_m_addr), 64'h100);
        drain();

        // Fairness: both clients requesting continuously
        i_req_addr  = {37'h300, 37'h200};
        i_req_tag   = {6'd2, 6'd1};
        i_req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("fair_req_rdy", 64'(o_req_rdy), 64'(fair_exp[i]));
            exp_q.push_back(fair_exp[i]);
            tick();
            check("fair_m_addr", 64'(o_m_addr), (fair_exp[i] == 2'b01) ? 64'h200 : 64'h300);
            check("fair_m_tag", 64'(o_m_tag), (fair_exp[i] == 2'b01) ? 64'd1 : 64'd2);
        end
        i_req_valid = '0;
        tick();
        drain();

        // Reset with one request outstanding: everything is forgotten.
        i_req_valid = 2'b01;
        #1;
        check("midrst_req_rdy", 64'(o_req_rdy), 64'h1);
        tick();
        i_req_valid = '0;
        check("midrst_pre_valid", 64'(o_m_valid), 64'd1);
        nrst = 1'b0;
        #1;
        check("midrst_m_valid", 64'(o_m_valid), 64'd0);
        check("midrst_m_addr", 64'(o_m_addr), 64'd0);
        i_m_rvalid = 1'b1;
        #1;
        check("midrst_m_rrdy", 64'(o_m_rrdy), 64'd0);
        check("midrst_rvalid", 64'(o_rvalid), 64'd0);
        i_m_rvalid = 1'b0;
        tick();
        nrst = 1'b1;
        tick();

        // Backpressure: register held, no client accepted
        i_m_rdy     = 1'b0;
        i_req_valid = 2'b11;
        #1;
        check("bp_first_rdy", 64'(o_req_rdy), 64'h1);
        exp_q.push_back(2'b01);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_req_rdy", 64'(o_req_rdy), 64'd0);
            check("bp_m_valid", 64'(o_m_valid), 64'd1);
            check("bp_m_addr", 64'(o_m_addr), 64'h200);
            check("bp_m_tag", 64'(o_m_tag), 64'd1);
            tick();
        end
`ifdef VXE_MARB_STATS_EN
        check("bp_stall_cnt", 64'(o_stall_cnt), 64'd4);
        check("bp_gnt_cnt", 64'(o_gnt_cnt), 64'd1);
`endif
        i_m_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 64'(o_req_rdy), 64'h2);
        exp_q.push_back(2'b10);
        tick();
        check("bp_release_addr", 64'(o_m_addr), 64'h300);
        check("bp_release_tag", 64'(o_m_tag), 64'd2);
        i_req_valid = '0;
        tick();
        drain();

        // FIFO full: 8 grants, the 9th waits for a pop registered on the previous cycle.
        i_req_valid = 2'b01;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("full_fill_rdy", 64'(o_req_rdy), 64'h1);
            exp_q.push_back(2'b01);
            tick();
        end
        #1;
        check("full_block_rdy", 64'(o_req_rdy), 64'd0);
        tick();
        check("full_m_valid", 64'(o_m_valid), 64'd0);
        i_m_rvalid = 1'b1;
        i_m_rdata  = 64'h55;
        i_rrdy     = '1;
        #1;
        check("full_pop_same_rdy", 64'(o_req_rdy), 64'd0);
        check("full_pop_rrdy", 64'(o_m_rrdy), 64'd1);
        check("full_pop_rvalid", 64'(o_rvalid), 64'h1);
        void'(exp_q.pop_front());
        tick();
        i_m_rvalid = 1'b0;
        #1;
        check("full_resume_rdy", 64'(o_req_rdy), 64'h1);
        exp_q.push_back(2'b01);
        tick();
        i_req_valid = '0;
        tick();
        drain();

        // Response routing: grants 1,0,1, client 0 not ready at first.
        i_req_valid = 2'b10;
        #1;
        check("route_g0", 64'(o_req_rdy), 64'h2);
        tick();
        i_req_valid = 2'b01;
        #1;
        check("route_g1", 64'(o_req_rdy), 64'h1);
        tick();
        i_req_valid = 2'b10;
        #1;
        check("route_g2", 64'(o_req_rdy), 64'h2);
        tick();
        i_req_valid = '0;
        tick();
        i_rrdy     = 2'b10;
        i_m_rvalid = 1'b1;
        i_m_rdata  = 64'hA;
        i_m_rtag   = 6'd3;
        #1;
        check("route_a_rvalid", 64'(o_rvalid), 64'h2);
        check("route_a_rrdy", 64'(o_m_rrdy), 64'd1);
        check("route_a_rdata", o_rdata, 64'hA);
        check("route_a_rtag", 64'(o_rtag), 64'd3);
        tick();
        i_m_rdata = 64'hB;
        #1;
        check("route_b_rvalid", 64'(o_rvalid), 64'h1);
        check("route_b_stall", 64'(o_m_rrdy), 64'd0);
        tick();
        check("route_b_still", 64'(o_m_rrdy), 64'd0);
        i_rrdy = 2'b11;
        #1;
        check("route_b_rrdy", 64'(o_m_rrdy), 64'd1);
        check("route_b_rdata", o_rdata, 64'hB);
        tick();
        i_m_rdata = 64'hC;
        #1;
        check("route_c_rvalid", 64'(o_rvalid), 64'h2);
        check("route_c_rrdy", 64'(o_m_rrdy), 64'd1);
        check("route_c_rdata", o_rdata, 64'hC);
        tick();
        check("route_empty_rvalid", 64'(o_rvalid), 64'd0);
        check("route_empty_rrdy", 64'(o_m_rrdy), 64'd0);
        i_m_rvalid = 1'b0;
        tick();

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vxe_vpu_mem_arb.md
Name: vxe_vpu_mem_arb

Overview:
- Round-robin arbiter sharing one memory read-request port between NCLI vector processing unit (VPU) load clients.
- Sits between the VPUs and the memory hub. Routes in-order read responses back to the requesting client using an order FIFO of granted client IDs.
- Sequences all VPU fetch traffic for the engine.

Parameters:
- NCLI, 2, number of clients (2..8).
- ADDR_W, 37, request address width (64-bit word address).
- DATA_W, 64, response data width.
- TAG_W, 6, client request tag width; passed through unchanged.
- DEPTH, 8, max outstanding requests; power of two, >=2.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- i_req_valid  in  NCLI  per-client request valid.
- i_req_addr  in  NCLI*ADDR_W  per-client address; client k at bits [k*ADDR_W +: ADDR_W].
- i_req_tag  in  NCLI*TAG_W  per-client tag; packed the same way.
- o_req_rdy  out  NCLI  per-client accept; one-hot or zero.
- o_m_valid  out  1  downstream request valid.
- o_m_addr  out  ADDR_W  downstream address.
- o_m_tag  out  TAG_W  downstream tag.
- i_m_rdy  in  1  downstream accept.
- i_m_rvalid  in  1  downstream response valid.
- i_m_rdata  in  DATA_W  response data.
- i_m_rtag  in  TAG_W  response tag.
- o_m_rrdy  out  1  response accept.
- o_rvalid  out  NCLI  per-client response valid; one-hot or zero.
- o_rdata  out  DATA_W  response data, shared by all clients.
- o_rtag  out  TAG_W  response tag, shared by all clients.
- i_rrdy  in  NCLI  per-client response ready.

Behaviour:
- Reset (nrst=0, asynchronous): o_m_valid=0, o_m_addr=0, o_m_tag=0, RR pointer=NCLI-1, order FIFO empty. All combinational outputs are therefore 0.
- Output register is one entry holding valid/addr/tag. It is free when o_m_valid=0 or (o_m_valid & i_m_rdy).
- Grant condition: register free AND FIFO count < DEPTH AND at least one i_req_valid. A pop in the same cycle does not unblock a full FIFO.
- Winner: the first requesting client in the order ptr+1, ptr+2, ... (mod NCLI).
- o_req_rdy[winner]=1 combinationally in the grant cycle; all other bits are 0.
- On grant:
  - register loads the winner's addr/tag and o_m_valid=1 next cycle;
  - winner ID is pushed to the FIFO;
  - ptr=winner.
- Latency: client request to o_m_valid is 1 cycle. Back-to-back grants are allowed while i_m_rdy=1 (full throughput).
- Register free with no request: o_m_valid=0 next cycle; addr/tag hold their old values.
- Register not free: o_req_rdy=0 on all clients; register contents are held stable.
- Response routing, with head = FIFO head ID:
  - o_rvalid[head] = i_m_rvalid & !empty;
  - o_m_rrdy = i_rrdy[head] & !empty;
  - o_rdata = i_m_rdata and o_rtag = i_m_rtag (pass-through, 0 cycles).
  - On i_m_rvalid & o_m_rrdy the FIFO pops.
- Response arriving with the FIFO empty: o_m_rrdy=0 and no o_rvalid asserted; the response is never accepted (protocol violation by the downstream).
- Simultaneous grant-push and response-pop: count is unchanged; both pointers advance modulo DEPTH.
- Responses return in grant order. The downstream memory hub guarantees in-order return.
- Reset asserted mid-operation: all state clears immediately and outstanding requests are forgotten. The system resets the hub at the same time.

Optional Feature:
- Macro VXE_MARB_STATS_EN.
- When defined, adds two outputs:
  - o_gnt_cnt (32-bit): increments on each grant;
  - o_stall_cnt (32-bit): increments each cycle with o_m_valid & !i_m_rdy.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Idle: NCLI=2, no requests for 10 cycles -> o_m_valid=0, o_req_rdy=0, o_rvalid=0 throughout.
- Single request: client 1 requests addr 37'h100 tag 5, i_m_rdy=1 -> o_req_rdy=2'b10 in cycle 0; o_m_valid/o_m_addr=0x100/o_m_tag=5 in cycle 1.
- Fairness: both clients request continuously for 6 cycles, i_m_rdy=1 -> grant sequence 0,1,0,1,0,1.
- Backpressure: i_m_rdy=0 for 4 cycles with both clients requesting -> request held stable, o_req_rdy=0.
  - With VXE_MARB_STATS_EN: o_stall_cnt=4 and o_gnt_cnt=1.
- FIFO full: DEPTH=8, 8 grants with no responses -> 9th request not granted. After 1 response pop, the grant resumes the following cycle.
- Response routing: grants order 1,0,1; three responses with data 0xA,0xB,0xC -> o_rvalid goes to client 1, then 0, then 1. With i_rrdy[0]=0, the second response stalls (o_m_rrdy=0) until i_rrdy[0]=1.
